inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 16: program memory entries, power of two, at most 32.
REQ-002 SHALL have parameter ADDR_W, default 4: equals log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_en, input, 1 bit: level request to load the program over din.
REQ-006 SHALL have port din, input, 16 bits: program half-word, high half first, then low half.
REQ-007 SHALL have port din_valid, input, 1 bit: din qualifier; each high cycle consumes one half-word while loading.
REQ-008 SHALL have port run, input, 1 bit: one-cycle pulse that starts fetching from address 0.
REQ-009 SHALL have port ir, output, 32 bits: fetched instruction to the execute stage; opcode in ir[31:27].
REQ-010 SHALL have port ir_valid, output, 1 bit: ir holds an instruction not yet consumed.
REQ-011 SHALL have port ir_ready, input, 1 bit: execute stage accepts ir.
REQ-012 SHALL have port pc, output, ADDR_W bits: address of the instruction currently in ir.
REQ-013 SHALL have port loaded, output, 1 bit: a complete program is resident.
REQ-014 SHALL have port halted, output, 1 bit: the fetch sequence has terminated.

Function
REQ-015 SHALL implement states IDLE, LOAD_HI, LOAD_LO, FETCH, HOLD and HALT.
REQ-016 IDLE and HALT: load_en=1 SHALL go to LOAD_HI with the load pointer at 0 and clear loaded; otherwise run=1 with loaded=1 SHALL go to FETCH with pc=0; run with loaded=0 SHALL be ignored.
REQ-017 load_en SHALL take priority over run when both are high in the same cycle.
REQ-018 LOAD_HI with din_valid SHALL latch din as the high half and go to LOAD_LO.
REQ-019 LOAD_LO with din_valid SHALL write {high half, din} to mem[load pointer] and increment the pointer.
REQ-020 After writing entry DEPTH-1, LOAD_LO SHALL go to IDLE, set loaded=1, and wrap the pointer to 0.
REQ-021 Cycles with din_valid=0 during a load SHALL cause no state change.
REQ-022 load_en falling during LOAD_HI or LOAD_LO SHALL abort to IDLE with loaded=0; already-written entries are retained.
REQ-023 FETCH SHALL read mem[pc] into ir and go to HOLD with ir_valid=1 on the next edge (read latency 1 cycle).
REQ-024 HOLD SHALL keep ir, pc and ir_valid stable while ir_ready=0.
REQ-025 A HOLD cycle with ir_valid and ir_ready both high is a transfer; ir_valid SHALL be 0 the following cycle.
REQ-026 After a transfer with pc=DEPTH-1, the block SHALL go to HALT with halted=1 and pc held; pc SHALL never wrap during a run.
REQ-027 After any other transfer, pc SHALL increment and the state SHALL go to FETCH; throughput is one instruction per 2 cycles.
REQ-028 load_en during FETCH or HOLD SHALL be ignored; the program memory SHALL NOT change while fetching.
REQ-029 halted SHALL clear on the edge that leaves HALT.
REQ-030 ir SHALL retain its last value while ir_valid=0.

Reset
REQ-031 Asserting sys_rst_n low SHALL immediately force: state IDLE, ir=0, ir_valid=0, pc=0, loaded=0, halted=0, load pointer 0, high-half latch 0.
REQ-032 Reset mid-load or mid-run SHALL abandon the operation.
REQ-033 Program memory contents SHALL be unaffected by reset, but loaded=0 requires a reload before run is honoured.
REQ-034 Reset deassertion SHALL take effect at the next rising clk edge with no extra wait cycles.

Configuration
REQ-035 The macro INST_FETCH_HALT_OP_EN SHALL select halt-opcode handling.
REQ-036 With INST_FETCH_HALT_OP_EN defined, a transfer of an instruction with ir[31:27]=5'b11111 SHALL go to HALT with halted=1, regardless of pc.
REQ-037 Without INST_FETCH_HALT_OP_EN, opcode 5'b11111 SHALL be passed through as an ordinary instruction.

Verification
REQ-038 Load path: load_en=1, 32 half-words with word i = {16'hA000+i, 16'h0000+i}, then run -> loaded=1 after the 32nd valid; run delivers ir=32'hA0000000, 32'hA0010001, ..., 32'hA00F000F with pc 0..15, then halted=1.
REQ-039 Backpressure: ir_ready=0 for 5 cycles at pc=3 -> ir, pc and ir_valid=1 held for those 5 cycles; ir_ready=1 -> pc=4 appears 2 cycles later.
REQ-040 Load abort: drop load_en after 7 half-words -> IDLE, loaded=0; a following run pulse produces no ir_valid.
REQ-041 Async reset: pull sys_rst_n low mid-HOLD at pc=9, between edges -> ir_valid=0, pc=0, loaded=0 with no clock edge; run after release is ignored.
REQ-042 Halt opcode, macro defined: mem[2]=32'hF8000000 -> transfers at pc 0, 1, 2, then halted=1 and no pc=3 fetch; macro undefined -> fetching continues through pc=15.
REQ-043 Priority: load_en and run high together in IDLE with loaded=1 -> state LOAD_HI and loaded=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: loads a program as 16-bit half-words, then streams it to execute.
// Define INST_FETCH_HALT_OP_EN to stop fetching when opcode 5'b11111 is transferred.
module inst_fetch #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              load_en,
  input  logic [15:0]       din,
  input  logic              din_valid,
  input  logic              run,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              loaded,
  output logic              halted
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoadHi = 3'd1;
  localparam logic [2:0] StLoadLo = 3'd2;
  localparam logic [2:0] StFetch  = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              loaded_q, loaded_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [15:0]       hi_q, hi_d;
  logic              mem_we;
  logic              halt_op;

  // Program storage has no reset so a reset never destroys a resident program.
  logic [31:0] mem [DEPTH];

`ifdef INST_FETCH_HALT_OP_EN
  assign halt_op = (ir_q[31:27] == 5'b11111);
`else
  assign halt_op = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_d       = pc_q;
    loaded_d   = loaded_q;
    halted_d   = halted_q;
    load_ptr_d = load_ptr_q;
    hi_d       = hi_q;
    mem_we     = 1'b0;
    case (state_q)
      StIdle, StHalt: begin
        if (load_en) begin
          state_d    = StLoadHi;
          load_ptr_d = '0;
          loaded_d   = 1'b0;
          halted_d   = 1'b0;
        end else if (run && loaded_q) begin
          state_d  = StFetch;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      StLoadHi: begin
        if (!load_en) begin
          state_d  = StIdle;
          loaded_d = 1'b0;
        end else if (din_valid) begin
          hi_d    = din;
          state_d = StLoadLo;
        end
      end
      StLoadLo: begin
        if (!load_en) begin
          state_d  = StIdle;
          loaded_d = 1'b0;
        end else if (din_valid) begin
          mem_we = 1'b1;
          if (load_ptr_q == LastAddr) begin
            state_d    = StIdle;
            loaded_d   = 1'b1;
            load_ptr_d = '0;
          end else begin
            load_ptr_d = load_ptr_q + ADDR_W'(1);
            state_d    = StLoadHi;
          end
        end
      end
      StFetch: begin
        ir_d       = mem[pc_q];
        ir_valid_d = 1'b1;
        state_d    = StHold;
      end
      StHold: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          // pc never wraps: the last entry ends the run.
          if (pc_q == LastAddr || halt_op) begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_q       <= '0;
      loaded_q   <= 1'b0;
      halted_q   <= 1'b0;
      load_ptr_q <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_q       <= pc_d;
      loaded_q   <= loaded_d;
      halted_q   <= halted_d;
      load_ptr_q <= load_ptr_d;
      hi_q       <= hi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_ptr_q] <= {hi_q, din};
    end
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign loaded   = loaded_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus pushes expected transfers, a monitor pops them.
// Expectations for the halt-opcode run follow INST_FETCH_HALT_OP_EN.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        load_en = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        run = 1'b0;
  logic        ir_ready = 1'b0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [3:0]  pc;
  logic        loaded;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  pc;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];

  inst_fetch #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .load_en   (load_en),
    .din       (din),
    .din_valid (din_valid),
    .run       (run),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc        (pc),
    .loaded    (loaded),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int prog, input int i);
    if (prog == 1 && i == 2) return 32'hF8000000;
    return {16'hA000 + 16'(i), 16'(i)};
  endfunction

  // Monitor: every accepted instruction is matched against the scoreboard.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sys_rst_n && ir_valid && ir_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected: got pc=%0d ir=%h expected no transfer", pc, ir);
        end else begin
          e = sb.pop_front();
          chk("xfer_pc", 32'(pc), 32'(e.pc));
          chk("xfer_ir", ir, e.ir);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int prog, input int nhalf);
    logic [31:0] w;
    load_en   = 1'b1;
    din_valid = 1'b0;
    tick();
    for (int k = 0; k < nhalf; k++) begin
      w         = word(prog, k / 2);
      din       = (k % 2 == 0) ? w[31:16] : w[15:0];
      din_valid = 1'b1;
      tick();
      if (k == 5) begin
        din_valid = 1'b0;
        tick();
        tick();
      end
    end
    din_valid = 1'b0;
    load_en   = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got ir_valid=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic xfer(input int prog, input int i);
    bit ok;
    wait_valid(ok);
    if (!ok) return;
    sb.push_back('{pc: 4'(i), ir: word(prog, i)});
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic expect_idle(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (ir_valid) seen = 1'b1;
      tick();
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    // Async reset with no clock edge yet
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    tick();

    pulse_run();
    expect_idle("run_unloaded_ignored", 6);

    load_prog(0, 32);
    chk("load_done", 32'(loaded), 32'd1);
    chk("load_halted", 32'(halted), 32'd0);

    // load_en wins over run
    load_en = 1'b1;
    run     = 1'b1;
    tick();
    run = 1'b0;
    chk("prio_loaded", 32'(loaded), 32'd0);
    chk("prio_no_fetch", 32'(ir_valid), 32'd0);

    // Abort after 7 half-words
    load_prog(0, 7);
    tick();
    chk("abort_loaded", 32'(loaded), 32'd0);
    pulse_run();
    expect_idle("abort_run_ignored", 6);

    // Full run with backpressure at pc=3
    load_prog(0, 32);
    chk("reload_done", 32'(loaded), 32'd1);
    pulse_run();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        bit ok;
        wait_valid(ok);
        for (int c = 0; c < 5; c++) begin
          chk("bp_valid", 32'(ir_valid), 32'd1);
          chk("bp_pc", 32'(pc), 32'd3);
          chk("bp_ir", ir, word(0, 3));
          tick();
        end
        xfer(0, 3);
        chk("post_xfer_valid", 32'(ir_valid), 32'd0);
        chk("post_xfer_pc", 32'(pc), 32'd4);
        tick();
        chk("pc4_valid", 32'(ir_valid), 32'd1);
        chk("pc4_pc", 32'(pc), 32'd4);
      end else begin
        xfer(0, i);
      end
    end
    tick();
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_pc", 32'(pc), 32'd15);
    chk("end_valid", 32'(ir_valid), 32'd0);
    chk("end_ir_kept", ir, word(0, 15));
    expect_idle("halt_no_wrap", 4);

    // Halt opcode at mem[2]
    load_prog(1, 32);
    chk("halt_prog_halted_clr", 32'(halted), 32'd0);
    pulse_run();
`ifdef INST_FETCH_HALT_OP_EN
    for (int i = 0; i < 3; i++) xfer(1, i);
    tick();
    chk("hop_halted", 32'(halted), 32'd1);
    chk("hop_pc", 32'(pc), 32'd2);
    expect_idle("hop_no_pc3", 6);
`else
    for (int i = 0; i < 16; i++) xfer(1, i);
    tick();
    chk("hop_halted", 32'(halted), 32'd1);
    chk("hop_pc", 32'(pc), 32'd15);
`endif

    // Reset in HOLD at pc=9, between edges
    load_prog(0, 32);
    pulse_run();
    for (int i = 0; i < 9; i++) xfer(0, i);
    begin
      bit ok;
      wait_valid(ok);
    end
    tick();
    chk("pre_rst_pc", 32'(pc), 32'd9);
    chk("pre_rst_valid", 32'(ir_valid), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ir_valid), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_loaded", 32'(loaded), 32'd0);
    chk("mid_rst_ir", ir, 32'h0);
    #2 sys_rst_n = 1'b1;
    tick();
    pulse_run();
    expect_idle("rst_run_ignored", 6);
    chk("rst_still_unloaded", 32'(loaded), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
